// File: rtl/vga_pkg.sv
// Shared timing constants for the VGA raster generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate derived from a
// 100 MHz system clock. CNT_W is the width of the hCount/vCount buses.
package vga_pkg;

  localparam int CNT_W           = 10;

  localparam int CLK_DIV_DEF     = 4;

  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACT_END_DEF   = 784;

  localparam int V_TOTAL_DEF     = 525;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_ACT_START_DEF = 35;
  localparam int V_ACT_END_DEF   = 515;

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis (horizontal or vertical) of the VGA timing generator.
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   inc     advance the count by one position on this clk
//   count   registered position, 0..TOTAL-1
//   sync_n  registered active-low sync, low while count < SYNC
//   wrap    combinational: count sits on its last position (TOTAL-1)
//   active  combinational: the count being loaded on this edge lies in
//           [ACT_START, ACT_END); the parent registers it so that the
//           qualifier lands on the same edge as the count it describes
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL     = H_TOTAL_DEF,
  parameter int SYNC      = H_SYNC_DEF,
  parameter int ACT_START = H_ACT_START_DEF,
  parameter int ACT_END   = H_ACT_END_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sync_n,
  output logic             active,
  output logic             wrap
);

  if (TOTAL < 1 || TOTAL > 1024) begin : g_bad_total
    $error("vga_axis_counter: TOTAL must lie in 1..1024");
  end
  if (!(SYNC < ACT_START && ACT_START < ACT_END && ACT_END <= TOTAL)) begin : g_bad_order
    $error("vga_axis_counter: need SYNC < ACT_START < ACT_END <= TOTAL");
  end

  logic [CNT_W-1:0] count_next;
  // One extra bit so ACT_END = 1024 still compares correctly.
  logic [CNT_W:0]   count_ext;

  assign wrap = (count == CNT_W'(TOTAL - 1));

  always_comb begin
    count_next = count;
    if (inc) begin
      count_next = wrap ? '0 : count + CNT_W'(1);
    end
  end

  assign count_ext = {1'b0, count_next};
  assign active    = (count_ext >= (CNT_W+1)'(ACT_START)) &&
                     (count_ext <  (CNT_W+1)'(ACT_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      sync_n <= 1'b0;
    end else begin
      count  <= count_next;
      sync_n <= !(count_ext < (CNT_W+1)'(SYNC));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a clock-enable pixel divider driving a
// horizontal and a vertical axis counter. Every output is a flop and all
// of them update on the same clk edge.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   hCount       column, 0..H_TOTAL-1
//   vCount       line, 0..V_TOTAL-1
//   hSync        active-low horizontal sync
//   vSync        active-low vertical sync
//   bright       high inside the active window
//   pix_en       one-clk pulse per pixel period
//   line_start   one-clk pulse on the edge hCount becomes 0
//   frame_start  one-clk pulse on the edge (hCount,vCount) becomes (0,0)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             pix_en,
  output logic             line_start,
  output logic             frame_start
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_active;
  logic             v_active;
  logic             v_inc;

  // tick is the pixel strobe for the edge about to happen; pix_en is its
  // registered copy, so pix_en rises on the same edge the counts advance.
  assign tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign v_inc = tick & h_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      bright      <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      pix_en      <= tick;
      line_start  <= v_inc;
      frame_start <= v_inc & v_wrap;
      bright      <= h_active & v_active;
    end
  end

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .SYNC      (H_SYNC),
    .ACT_START (H_ACT_START),
    .ACT_END   (H_ACT_END)
  ) u_h (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (tick),
    .count  (hCount),
    .sync_n (hSync),
    .active (h_active),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .SYNC      (V_SYNC),
    .ACT_START (V_ACT_START),
    .ACT_END   (V_ACT_END)
  ) u_v (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (v_inc),
    .count  (vCount),
    .sync_n (vSync),
    .active (v_active),
    .wrap   (v_wrap)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-geometry instance plus two
// scaled-down geometries (CLK_DIV=3 and CLK_DIV=1) so whole frames fit in
// a short run. A closed-form model of the raster, indexed by clk count
// since reset release, feeds a scoreboard queue.
module tb_vga_timing_gen;

  localparam int S_D = 3;
  localparam int F_D = 1;
  localparam int S_HT = 20, S_HS = 3, S_HAS = 5, S_HAE = 17;
  localparam int S_VT = 12, S_VS = 2, S_VAS = 3, S_VAE = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int k = 0;

  logic [9:0] d_h, d_v, s_h, s_v, f_h, f_v;
  logic d_hs, d_vs, d_br, d_pe, d_ls, d_fs;
  logic s_hs, s_vs, s_br, s_pe, s_ls, s_fs;
  logic f_hs, f_vs, f_br, f_pe, f_ls, f_fs;
  logic [25:0] act_d, act_s, act_f;

  assign act_d = {d_h, d_v, d_hs, d_vs, d_br, d_pe, d_ls, d_fs};
  assign act_s = {s_h, s_v, s_hs, s_vs, s_br, s_pe, s_ls, s_fs};
  assign act_f = {f_h, f_v, f_hs, f_vs, f_br, f_pe, f_ls, f_fs};

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .hCount(d_h), .vCount(d_v), .hSync(d_hs),
    .vSync(d_vs), .bright(d_br), .pix_en(d_pe), .line_start(d_ls),
    .frame_start(d_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(S_D), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACT_START(S_HAS),
    .H_ACT_END(S_HAE), .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_ACT_START(S_VAS),
    .V_ACT_END(S_VAE)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .hCount(s_h), .vCount(s_v), .hSync(s_hs),
    .vSync(s_vs), .bright(s_br), .pix_en(s_pe), .line_start(s_ls),
    .frame_start(s_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(F_D), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACT_START(S_HAS),
    .H_ACT_END(S_HAE), .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_ACT_START(S_VAS),
    .V_ACT_END(S_VAE)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .hCount(f_h), .vCount(f_v), .hSync(f_hs),
    .vSync(f_vs), .bright(f_br), .pix_en(f_pe), .line_start(f_ls),
    .frame_start(f_fs)
  );

  typedef struct {
    int          id;
    int          kk;
    logic [25:0] exp;
  } sb_t;

  sb_t sb_q[$];

  // Raster state after clk edge kk (kk=1 is the first edge after release):
  // kk/d whole pixels have elapsed since (0,0).
  function automatic logic [25:0] model(int kk, int d, int ht, int hs, int has,
                                        int hae, int vt, int vs, int vas, int vae);
    int p, h, v;
    logic pe, hsn, vsn, br, ls, fs;
    logic [9:0] hb, vb;
    if (kk == 0) return '0;
    pe  = ((kk % d) == 0);
    p   = kk / d;
    h   = p % ht;
    v   = (p / ht) % vt;
    hsn = !(h < hs);
    vsn = !(v < vs);
    br  = (h >= has) && (h < hae) && (v >= vas) && (v < vae);
    ls  = pe && (h == 0);
    fs  = ls && (v == 0);
    hb  = h[9:0];
    vb  = v[9:0];
    return {hb, vb, hsn, vsn, br, pe, ls, fs};
  endfunction

  task automatic advance();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (act_d !== 26'd0) begin errors++; $display("FAIL reset_def actual=%h required=0", act_d); end
    checks++;
    if (act_s !== 26'd0) begin errors++; $display("FAIL reset_small actual=%h required=0", act_s); end
    checks++;
    if (act_f !== 26'd0) begin errors++; $display("FAIL reset_fast actual=%h required=0", act_f); end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_first_pixel();
    logic       exp_pe;
    logic [9:0] exp_h;
    for (int i = 0; i < 5; i++) begin
      advance();
      exp_pe = (k == 4);
      exp_h  = (k >= 4) ? 10'd1 : 10'd0;
      checks++;
      if (d_pe !== exp_pe) begin errors++; $display("FAIL first_pix_en clk=%0d actual=%b required=%b", k, d_pe, exp_pe); end
      checks++;
      if (d_h !== exp_h) begin errors++; $display("FAIL first_hcount clk=%0d actual=%0d required=%0d", k, d_h, exp_h); end
      checks++;
      if (f_pe !== 1'b1 || f_h !== 10'(k)) begin
        errors++; $display("FAIL div1_every_clk clk=%0d actual pe=%b h=%0d required pe=1 h=%0d", k, f_pe, f_h, k);
      end
    end
  endtask

  task automatic test_scoreboard(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      sb_q.push_back('{0, k, model(k, 4, 800, 96, 144, 784, 525, 2, 35, 515)});
      sb_q.push_back('{1, k, model(k, S_D, S_HT, S_HS, S_HAS, S_HAE, S_VT, S_VS, S_VAS, S_VAE)});
      sb_q.push_back('{2, k, model(k, F_D, S_HT, S_HS, S_HAS, S_HAE, S_VT, S_VS, S_VAS, S_VAE)});
      #1;
      while (sb_q.size() > 0) begin
        sb_t e;
        logic [25:0] a;
        e = sb_q.pop_front();
        a = (e.id == 0) ? act_d : (e.id == 1) ? act_s : act_f;
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL sb_inst%0d clk=%0d actual=%h required=%h", e.id, e.kk, a, e.exp);
        end
      end
    end
  endtask

  // Entered with k at a frame boundary of the small geometry (720 clks).
  task automatic test_frame_small();
    int hs_low = 0, vs_low = 0, ls_cnt = 0, fs_cnt = 0, br_pix = 0, fs_k = -1;
    int fh = -1, fv = -1, lh = -1, lv = -1;
    logic fs_with_ls = 1'b0;
    for (int i = 0; i < 720; i++) begin
      advance();
      if (!s_hs) hs_low++;
      if (!s_vs) vs_low++;
      if (s_ls) ls_cnt++;
      if (s_fs) begin
        fs_cnt++;
        fs_k = k;
        fs_with_ls = s_ls && (s_h == 10'd0) && (s_v == 10'd0);
      end
      if (s_br && s_pe) begin
        if (fh < 0) begin fh = int'(s_h); fv = int'(s_v); end
        lh = int'(s_h);
        lv = int'(s_v);
        br_pix++;
      end
    end
    checks++;
    if (hs_low != 108) begin errors++; $display("FAIL hsync_low_clks actual=%0d required=108", hs_low); end
    checks++;
    if (vs_low != 120) begin errors++; $display("FAIL vsync_low_clks actual=%0d required=120", vs_low); end
    checks++;
    if (ls_cnt != 12) begin errors++; $display("FAIL line_start_count actual=%0d required=12", ls_cnt); end
    checks++;
    if (fs_cnt != 1 || fs_k != 1440) begin errors++; $display("FAIL frame_start actual count=%0d clk=%0d required count=1 clk=1440", fs_cnt, fs_k); end
    checks++;
    if (!fs_with_ls) begin errors++; $display("FAIL frame_wrap_coincident actual=0 required=1"); end
    checks++;
    if (br_pix != 84) begin errors++; $display("FAIL bright_pixels actual=%0d required=84", br_pix); end
    checks++;
    if (fh != 5 || fv != 3) begin errors++; $display("FAIL bright_first actual=(%0d,%0d) required=(5,3)", fh, fv); end
    checks++;
    if (lh != 16 || lv != 9) begin errors++; $display("FAIL bright_last actual=(%0d,%0d) required=(16,9)", lh, lv); end
  endtask

  task automatic test_line_wrap_default();
    int f_prev = -1, f_last = -1, hs_low = 0, ls_cnt = 0;
    while (k < 3196) begin
      advance();
      if (f_ls) begin f_prev = f_last; f_last = k; end
    end
    checks++;
    if (d_h !== 10'd799 || d_v !== 10'd0) begin errors++; $display("FAIL pre_wrap actual=(%0d,%0d) required=(799,0)", d_h, d_v); end
    repeat (4) begin
      advance();
      if (f_ls) begin f_prev = f_last; f_last = k; end
    end
    checks++;
    if (d_h !== 10'd0 || d_v !== 10'd1 || d_ls !== 1'b1 || d_pe !== 1'b1 || d_fs !== 1'b0) begin
      errors++; $display("FAIL line_wrap actual h=%0d v=%0d ls=%b pe=%b fs=%b required h=0 v=1 ls=1 pe=1 fs=0", d_h, d_v, d_ls, d_pe, d_fs);
    end
    advance();
    checks++;
    if (d_ls !== 1'b0 || d_h !== 10'd0) begin errors++; $display("FAIL line_start_width actual ls=%b h=%0d required ls=0 h=0", d_ls, d_h); end
    if (!d_hs) hs_low++;
    while (k < 6400) begin
      advance();
      if (!d_hs) hs_low++;
      if (d_ls) ls_cnt++;
    end
    checks++;
    if (hs_low != 384) begin errors++; $display("FAIL hsync_low_def actual=%0d required=384", hs_low); end
    checks++;
    if (ls_cnt != 1 || d_v !== 10'd2 || d_h !== 10'd0) begin
      errors++; $display("FAIL line_period_def actual ls=%0d v=%0d h=%0d required ls=1 v=2 h=0", ls_cnt, d_v, d_h);
    end
    checks++;
    if (f_last - f_prev != 20) begin errors++; $display("FAIL div1_line_period actual=%0d required=20", f_last - f_prev); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!(s_h == 10'd10 && s_v == 10'd6) && guard < 2000) begin
      advance();
      guard++;
    end
    checks++;
    if (guard >= 2000) begin errors++; $display("FAIL mid_target_timeout actual=(%0d,%0d) required=(10,6)", s_h, s_v); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act_d !== 26'd0) begin errors++; $display("FAIL mid_reset_def actual=%h required=0", act_d); end
    checks++;
    if (act_s !== 26'd0) begin errors++; $display("FAIL mid_reset_small actual=%h required=0", act_s); end
    checks++;
    if (act_f !== 26'd0) begin errors++; $display("FAIL mid_reset_fast actual=%h required=0", act_f); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_s !== 26'd0) begin errors++; $display("FAIL mid_reset_hold actual=%h required=0", act_s); end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_scoreboard(715);
    test_frame_small();
    test_line_wrap_default();
    test_reset_mid();
    test_scoreboard(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
